// File: rtl/apb_reg_completer.sv
// APB completer: a bank of NREGS 16-bit RW control registers plus one read-only status word.
// The register bank is exported flat, with a one-cycle write pulse per register.
// Every access waits a fixed number of cycles, set by WAIT_CYCLES.
// PSLVERR is raised on an access to an unmapped address, or on a write to the status word.
module apb_reg_completer #(
    parameter int unsigned ADDRS       = 4,
    parameter int unsigned NREGS       = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [1:0]           pstrb_i,
    input  logic [ADDRS-1:0]     paddr_i,
    input  logic [15:0]          pwdata_i,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic [15:0]          prdata_o,
    input  logic [15:0]          sta_i,
    output logic [16*NREGS-1:0]  regs_o,
    output logic [NREGS-1:0]     reg_wr_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [ADDRS-1:0] STA_ADDR = ADDRS'(NREGS);
    localparam logic [3:0]       CNT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDRS-1:0]       addr_q, addr_d;
    logic                   write_q, write_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [1:0]             strb_q, strb_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [15:0]            prdata_q, prdata_d;
    logic [NREGS-1:0][15:0] regs_q, regs_d;
    logic [NREGS-1:0]       reg_wr_q, reg_wr_d;

    logic setup;
    logic access;

    assign setup  = psel_i && !penable_i;
    assign access = psel_i && penable_i;

    // Read mux over the register bank and the status word. Unmapped addresses read as zero.
    function automatic logic [15:0] read_word(input logic [ADDRS-1:0]     a,
                                              input logic [NREGS-1:0][15:0] bank,
                                              input logic [15:0]            sta);
        logic [15:0] v;
        v = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            if (a == ADDRS'(k)) v = bank[k];
        end
        if (a == STA_ADDR) v = sta;
        return v;
    endfunction

    // Reads may go up to the status word; writes must stay below it.
    function automatic logic access_err(input logic [ADDRS-1:0] a, input logic wr);
        return wr ? (a >= STA_ADDR) : (a > STA_ADDR);
    endfunction

    // Commit the captured write on the edge that leaves RESP, with byte-lane merge.
    always_comb begin
        regs_d   = regs_q;
        reg_wr_d = '0;
        if (state_q == RESP && write_q && strb_q != 2'b00) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                if (addr_q == ADDRS'(k)) begin
                    if (strb_q[0]) regs_d[k][7:0]  = wdata_q[7:0];
                    if (strb_q[1]) regs_d[k][15:8] = wdata_q[15:8];
                    reg_wr_d[k] = 1'b1;
                end
            end
        end
    end

    // Transfer FSM: capture the setup, count wait states, then present a one-cycle response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (setup) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    strb_d  = pstrb_i;
                    cnt_d   = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        // Read through regs_d so a setup taken on the RESP edge sees its own write.
                        pready_d  = 1'b1;
                        pslverr_d = access_err(paddr_i, pwrite_i);
                        prdata_d  = pwrite_i ? 16'h0000 : read_word(paddr_i, regs_d, sta_i);
                        state_d   = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!access) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = access_err(addr_q, write_q);
                        prdata_d  = write_q ? 16'h0000 : read_word(addr_q, regs_d, sta_i);
                        state_d   = RESP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            regs_q    <= '0;
            reg_wr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;
    assign regs_o    = regs_q;
    assign reg_wr_o  = reg_wr_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer.
// Three instances share one requester: WAIT_CYCLES = 0, 1 and 3.
// tgt selects which instance the requester talks to and which one is observed.
module tb_apb_reg_completer;

    logic        clock = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [1:0]  pstrb;
    logic [3:0]  paddr;
    logic [15:0] pwdata, sta;
    int          tgt;

    always #5 clock = ~clock;

    logic         psel_w0, psel_w1, psel_w3;
    logic         pready_w0, pready_w1, pready_w3;
    logic         pslverr_w0, pslverr_w1, pslverr_w3;
    logic [15:0]  prdata_w0, prdata_w1, prdata_w3;
    logic [127:0] regs_w0, regs_w1, regs_w3;
    logic [7:0]   reg_wr_w0, reg_wr_w1, reg_wr_w3;

    assign psel_w0 = psel && (tgt == 0);
    assign psel_w1 = psel && (tgt == 1);
    assign psel_w3 = psel && (tgt == 3);

    apb_reg_completer #(.ADDRS(4), .NREGS(8), .WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .reset(reset), .psel_i(psel_w0), .penable_i(penable),
        .pwrite_i(pwrite), .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready_w0), .pslverr_o(pslverr_w0), .prdata_o(prdata_w0),
        .sta_i(sta), .regs_o(regs_w0), .reg_wr_o(reg_wr_w0)
    );
    apb_reg_completer #(.ADDRS(4), .NREGS(8), .WAIT_CYCLES(1)) u_w1 (
        .clock(clock), .reset(reset), .psel_i(psel_w1), .penable_i(penable),
        .pwrite_i(pwrite), .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready_w1), .pslverr_o(pslverr_w1), .prdata_o(prdata_w1),
        .sta_i(sta), .regs_o(regs_w1), .reg_wr_o(reg_wr_w1)
    );
    apb_reg_completer #(.ADDRS(4), .NREGS(8), .WAIT_CYCLES(3)) u_w3 (
        .clock(clock), .reset(reset), .psel_i(psel_w3), .penable_i(penable),
        .pwrite_i(pwrite), .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready_w3), .pslverr_o(pslverr_w3), .prdata_o(prdata_w3),
        .sta_i(sta), .regs_o(regs_w3), .reg_wr_o(reg_wr_w3)
    );

    logic         cur_pready, cur_pslverr;
    logic [15:0]  cur_prdata;
    logic [127:0] cur_regs;
    logic [7:0]   cur_reg_wr;

    // Observe the currently targeted instance.
    always_comb begin
        cur_pready  = pready_w1;
        cur_pslverr = pslverr_w1;
        cur_prdata  = prdata_w1;
        cur_regs    = regs_w1;
        cur_reg_wr  = reg_wr_w1;
        if (tgt == 0) begin
            cur_pready  = pready_w0;
            cur_pslverr = pslverr_w0;
            cur_prdata  = prdata_w0;
            cur_regs    = regs_w0;
            cur_reg_wr  = reg_wr_w0;
        end else if (tgt == 3) begin
            cur_pready  = pready_w3;
            cur_pslverr = pslverr_w3;
            cur_prdata  = prdata_w3;
            cur_regs    = regs_w3;
            cur_reg_wr  = reg_wr_w3;
        end
    end

    int assertions = 0;
    int failures   = 0;

    // Snapshots taken during the setup cycle and the access cycles of the last transfer.
    logic [7:0]   setup_reg_wr;
    logic [127:0] setup_regs;
    logic [7:0]   acc_reg_wr;

    // One APB transfer. Returns after sampling the pready cycle, leaving the bus in its
    // access phase, so a following call runs back-to-back. cycles = 0 means pready never came.
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                            input logic [1:0] strb, output logic [15:0] rdata,
                            output logic err, output int cycles);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clock);
        setup_reg_wr = cur_reg_wr;
        setup_regs   = cur_regs;
        @(posedge clock); #1;
        penable    = 1'b1;
        cycles     = 0;
        rdata      = 16'h0000;
        err        = 1'b0;
        acc_reg_wr = 8'h00;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            acc_reg_wr = acc_reg_wr | cur_reg_wr;
            if (cur_pready) begin
                cycles = n;
                rdata  = cur_prdata;
                err    = cur_pslverr;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic bus_idle();
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        assertions++;
        if (pready_w1 !== 1'b0 || pslverr_w1 !== 1'b0 || prdata_w1 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_resp: got rdy=%b err=%b rd=%h, want 0 0 0000",
                     pready_w1, pslverr_w1, prdata_w1);
        end
        assertions++;
        if ({regs_w0, regs_w1, regs_w3} !== 384'h0) begin
            failures++;
            $display("FAIL reset_regs: got %h %h %h, want all zero", regs_w0, regs_w1, regs_w3);
        end
        assertions++;
        if ({reg_wr_w0, reg_wr_w1, reg_wr_w3, pready_w0, pready_w3} !== 26'h0) begin
            failures++;
            $display("FAIL reset_pulses: got wr %h %h %h rdy %b %b, want 0",
                     reg_wr_w0, reg_wr_w1, reg_wr_w3, pready_w0, pready_w3);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // T1: full write with one wait state; pready in the second access cycle.
    task automatic test_write();
        logic [15:0] rd; logic er; int cy;
        tgt = 1;
        apb_xfer(1'b1, 4'd3, 16'hBEEF, 2'b11, rd, er, cy);
        assertions++;
        if (cy !== 2) begin failures++; $display("FAIL t1_ready_cycle: got %0d want 2", cy); end
        assertions++;
        if (er !== 1'b0) begin failures++; $display("FAIL t1_err: got %b want 0", er); end
    endtask

    // T2: read immediately after T1; T1's pulse shows in the read's setup cycle only.
    task automatic test_back_to_back();
        logic [15:0] rd; logic er; int cy;
        apb_xfer(1'b0, 4'd3, 16'h0000, 2'b00, rd, er, cy);
        assertions++;
        if (setup_reg_wr !== 8'h08) begin
            failures++; $display("FAIL t1_pulse: got %h want 08", setup_reg_wr);
        end
        assertions++;
        if (setup_regs[63:48] !== 16'hBEEF) begin
            failures++; $display("FAIL t1_reg3: got %h want beef", setup_regs[63:48]);
        end
        assertions++;
        if (acc_reg_wr !== 8'h00) begin
            failures++; $display("FAIL t1_pulse_len: got %h want 00", acc_reg_wr);
        end
        assertions++;
        if (cy !== 2 || rd !== 16'hBEEF || er !== 1'b0) begin
            failures++; $display("FAIL t2_read: got cy=%0d rd=%h err=%b want 2 beef 0", cy, rd, er);
        end
        bus_idle();
        @(negedge clock);
        assertions++;
        if (cur_pready !== 1'b0 || cur_prdata !== 16'h0000 || cur_pslverr !== 1'b0) begin
            failures++;
            $display("FAIL t2_after: got rdy=%b rd=%h err=%b want 0 0000 0",
                     cur_pready, cur_prdata, cur_pslverr);
        end
    endtask

    // T3: byte-lane strobes, and an all-zero strobe that must be a silent no-op.
    task automatic test_strobes();
        logic [15:0] rd; logic er; int cy;
        tgt = 1;
        apb_xfer(1'b1, 4'd3, 16'h1234, 2'b01, rd, er, cy);
        bus_idle();
        @(negedge clock);
        assertions++;
        if (cur_regs[63:48] !== 16'hBE34 || cur_reg_wr !== 8'h08 || er !== 1'b0) begin
            failures++;
            $display("FAIL t3_lane0: got reg=%h wr=%h err=%b want be34 08 0",
                     cur_regs[63:48], cur_reg_wr, er);
        end
        apb_xfer(1'b1, 4'd3, 16'hFFFF, 2'b00, rd, er, cy);
        assertions++;
        if (cy !== 2 || er !== 1'b0) begin
            failures++; $display("FAIL t3_nostrb_resp: got cy=%0d err=%b want 2 0", cy, er);
        end
        bus_idle();
        @(negedge clock);
        assertions++;
        if (cur_regs[63:48] !== 16'hBE34 || cur_reg_wr !== 8'h00) begin
            failures++;
            $display("FAIL t3_nostrb: got reg=%h wr=%h want be34 00", cur_regs[63:48], cur_reg_wr);
        end
    endtask

    // T4: status word read, write to status, read of an unmapped address.
    task automatic test_status_unmapped();
        logic [15:0] rd; logic er; int cy;
        logic [127:0] exp_regs;
        tgt = 1;
        exp_regs        = '0;
        exp_regs[63:48] = 16'hBE34;
        sta = 16'h5A5A;
        apb_xfer(1'b0, 4'd8, 16'h0000, 2'b00, rd, er, cy);
        assertions++;
        if (rd !== 16'h5A5A || er !== 1'b0) begin
            failures++; $display("FAIL t4_sta_read: got rd=%h err=%b want 5a5a 0", rd, er);
        end
        apb_xfer(1'b1, 4'd8, 16'hFFFF, 2'b11, rd, er, cy);
        assertions++;
        if (er !== 1'b1) begin failures++; $display("FAIL t4_sta_write_err: got %b want 1", er); end
        bus_idle();
        @(negedge clock);
        assertions++;
        if (cur_regs !== exp_regs || cur_reg_wr !== 8'h00) begin
            failures++;
            $display("FAIL t4_sta_write_fx: got regs=%h wr=%h want %h 00",
                     cur_regs, cur_reg_wr, exp_regs);
        end
        apb_xfer(1'b0, 4'd12, 16'h0000, 2'b00, rd, er, cy);
        assertions++;
        if (rd !== 16'h0000 || er !== 1'b1) begin
            failures++; $display("FAIL t4_unmapped: got rd=%h err=%b want 0000 1", rd, er);
        end
        bus_idle();
    endtask

    // T5: three wait states; the requester abandons the first transfer after one access cycle.
    task automatic test_abort();
        logic [15:0] rd; logic er; int cy;
        logic seen_rdy; logic [7:0] seen_wr;
        tgt = 3;
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 16'hAAAA;
        pstrb = 2'b11;
        @(posedge clock); #1;
        penable = 1'b1;
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0;
        seen_rdy = 1'b0;
        seen_wr  = 8'h00;
        repeat (6) begin
            @(negedge clock);
            seen_rdy = seen_rdy | cur_pready;
            seen_wr  = seen_wr | cur_reg_wr;
        end
        assertions++;
        if (seen_rdy !== 1'b0 || seen_wr !== 8'h00 || cur_regs[31:16] !== 16'h0000) begin
            failures++;
            $display("FAIL t5_abort: got rdy=%b wr=%h reg1=%h want 0 00 0000",
                     seen_rdy, seen_wr, cur_regs[31:16]);
        end
        apb_xfer(1'b1, 4'd1, 16'h1111, 2'b11, rd, er, cy);
        assertions++;
        if (cy !== 4 || er !== 1'b0) begin
            failures++; $display("FAIL t5_next_write: got cy=%0d err=%b want 4 0", cy, er);
        end
        apb_xfer(1'b0, 4'd1, 16'h0000, 2'b00, rd, er, cy);
        assertions++;
        if (cy !== 4 || rd !== 16'h1111 || setup_reg_wr !== 8'h02) begin
            failures++;
            $display("FAIL t5_next_read: got cy=%0d rd=%h wr=%h want 4 1111 02", cy, rd, setup_reg_wr);
        end
        bus_idle();
    endtask

    // T6: reset raised during the access phase of a write to address 0.
    task automatic test_reset_abort();
        tgt = 1;
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 16'h1234;
        pstrb = 2'b11;
        @(posedge clock); #1;
        penable = 1'b1;
        reset   = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clock);
        assertions++;
        if (cur_pready !== 1'b0 || cur_pslverr !== 1'b0 || cur_prdata !== 16'h0000 ||
            cur_regs !== 128'h0 || cur_reg_wr !== 8'h00) begin
            failures++;
            $display("FAIL t6_reset: got rdy=%b err=%b rd=%h regs=%h wr=%h want all 0",
                     cur_pready, cur_pslverr, cur_prdata, cur_regs, cur_reg_wr);
        end
        @(negedge clock);
        assertions++;
        if (cur_reg_wr !== 8'h00 || cur_regs[15:0] !== 16'h0000 || regs_w3 !== 128'h0) begin
            failures++;
            $display("FAIL t6_no_commit: got wr=%h reg0=%h w3regs=%h want 0",
                     cur_reg_wr, cur_regs[15:0], regs_w3);
        end
    endtask

    // T6 variant: zero wait states, pready in the first access cycle, read-after-write.
    task automatic test_zero_wait();
        logic [15:0] rd; logic er; int cy;
        tgt = 0;
        apb_xfer(1'b1, 4'd2, 16'h0F0F, 2'b11, rd, er, cy);
        assertions++;
        if (cy !== 1 || er !== 1'b0) begin
            failures++; $display("FAIL w0_write: got cy=%0d err=%b want 1 0", cy, er);
        end
        apb_xfer(1'b0, 4'd2, 16'h0000, 2'b00, rd, er, cy);
        assertions++;
        if (cy !== 1 || rd !== 16'h0F0F || setup_reg_wr !== 8'h04) begin
            failures++;
            $display("FAIL w0_read: got cy=%0d rd=%h wr=%h want 1 0f0f 04", cy, rd, setup_reg_wr);
        end
        bus_idle();
        @(negedge clock);
        assertions++;
        if (cur_pready !== 1'b0 || cur_prdata !== 16'h0000) begin
            failures++;
            $display("FAIL w0_after: got rdy=%b rd=%h want 0 0000", cur_pready, cur_prdata);
        end
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 2'b00;
        paddr = 4'd0; pwdata = 16'h0000; sta = 16'h0000; tgt = 1;
        test_reset();
        test_write();
        test_back_to_back();
        test_strobes();
        test_status_unmapped();
        test_abort();
        test_reset_abort();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
